// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Multiplies complete after MUL_CYCLES; divides use a 32-step restoring divider.
module mul_div_unit #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    localparam int CW = 5;
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic          sgn;
    logic [31:0]   quo;
    logic [31:0]   rem;

    logic          accept;
    logic          last;
    logic          is_mul;
    logic          is_div;
    logic          sgn_in;
    logic [31:0]   a_mag;
    logic [31:0]   dvs;
    logic [63:0]   m_a;
    logic [63:0]   m_b;
    logic [63:0]   prod;
    logic [32:0]   step_in;
    logic          step_ge;
    logic [31:0]   rem_nx;
    logic [31:0]   quo_nx;
    logic          q_neg;
    logic          r_neg;
    logic [31:0]   q_fix;
    logic [31:0]   r_fix;

    assign busy   = (state != IDLE);
    assign accept = start && (state == IDLE);
    assign last   = (cnt == '0);
    assign is_mul = (op[2:1] == 2'b00);
    assign is_div = (op[2:1] == 2'b01);
    assign sgn_in = ~op[0];
    assign a_mag  = (sgn_in && a[31]) ? -a : a;

    // Low 64 bits of a 64x64 product are exact for both signednesses.
    assign m_a  = {{32{sgn & a_q[31]}}, a_q};
    assign m_b  = {{32{sgn & b_q[31]}}, b_q};
    assign prod = m_a * m_b;

    assign dvs     = (sgn && b_q[31]) ? -b_q : b_q;
    assign step_in = {rem, quo[31]};
    assign step_ge = step_in >= {1'b0, dvs};
    assign rem_nx  = step_ge ? 32'(step_in - {1'b0, dvs}) : step_in[31:0];
    assign quo_nx  = {quo[30:0], step_ge};

    // Quotient truncates toward zero; remainder follows the dividend.
    assign q_neg = sgn & (a_q[31] ^ b_q[31]);
    assign r_neg = sgn & a_q[31];
    assign q_fix = q_neg ? -quo_nx : quo_nx;
    assign r_fix = r_neg ? -rem_nx : rem_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept && is_mul) begin
                    state_nx = MUL;
                end else if (accept && is_div) begin
                    state_nx = DIV;
                end
            end
            MUL, DIV: begin
                if (last) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            sgn  <= 1'b0;
            quo  <= '0;
            rem  <= '0;
            hi   <= '0;
            lo   <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (op)
                            3'b100: hi <= a;
                            3'b101: lo <= a;
                            default: ;
                        endcase
                        if (is_mul || is_div) begin
                            a_q <= a;
                            b_q <= b;
                            sgn <= sgn_in;
                            quo <= a_mag;
                            rem <= '0;
                            cnt <= is_mul ? MUL_LOAD : DIV_LOAD;
                        end
                    end
                end
                MUL: begin
                    if (last) begin
                        hi   <= prod[63:32];
                        lo   <= prod[31:0];
                        done <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DIV: begin
                    quo <= quo_nx;
                    rem <= rem_nx;
                    if (last) begin
                        done <= 1'b1;
                        if (b_q == '0) begin
                            lo <= 32'hFFFF_FFFF;
                            hi <= a_q;
                        end else begin
                            lo <= q_fix;
                            hi <= r_fix;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed vectors, a monitor checks
// every done pulse against queued expectations (values and cycle).
module tb_mul_div_unit;

    localparam int MULC = 5;
    localparam int DIVC = 32;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int   cyc;
    int   errors;
    int   checks;
    exp_t exp_q[$];

    mul_div_unit #(.MUL_CYCLES(MULC), .DIV_CYCLES(DIVC)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .op   (op),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .hi   (hi),
        .lo   (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d want none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk({e.name, "_hi"}, hi, e.hi);
                    chk({e.name, "_lo"}, lo, e.lo);
                    chk({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
                    chk({e.name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
                end
            end
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] eh,
                         input logic [31:0] el, input int lat,
                         input string nm);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'hA5A5_A5A5;
        b     = 32'h5A5A_5A5A;
        e.hi   = eh;
        e.lo   = el;
        e.due  = cyc + lat;
        e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input int lat, input bit poke, input string nm);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            if (poke && n == 0) begin
                start = 1'b1;
                op    = 3'b011;
                a     = 32'd9;
                b     = 32'd3;
            end else begin
                start = 1'b0;
            end
            n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({nm, "_busy_cycles"}, 32'(n), 32'(lat));
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eh,
                       input logic [31:0] el, input int lat,
                       input string nm);
        issue(o, x, y, eh, el, lat, nm);
        wait_idle(lat, 1'b0, nm);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        op     = 3'b000;
        a      = '0;
        b      = '0;
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        rst_n = 1'b1;

        run(3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, MULC, "mult_m3x5");
        run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MULC, "multu_max");
        run(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, MULC, "mult_m1xm1");

        start = 1'b1;
        op    = 3'b101;
        a     = 32'h0000_CAFE;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("mtlo_lo", lo, 32'h0000_CAFE);
        chk("mtlo_hi", hi, 32'h0);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);

        run(3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIVC, "div_m7by2");
        run(3'b011, 32'd100, 32'd7, 32'd2, 32'd14, DIVC, "divu_100by7");
        run(3'b011, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, DIVC, "divu_by0");
        run(3'b010, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, DIVC, "div_neg_by0");
        run(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, DIVC, "div_ovf");

        issue(3'b000, 32'd2, 32'd3, 32'd0, 32'd6, MULC, "mult_2x3");
        wait_idle(MULC, 1'b1, "mult_2x3");

        start = 1'b1;
        op    = 3'b100;
        a     = 32'h0000_1234;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("mthi_b2b_hi", hi, 32'h0000_1234);
        chk("mthi_b2b_lo", lo, 32'd6);
        chk("mthi_b2b_busy", {31'd0, busy}, 32'd0);
        chk("mthi_b2b_done", {31'd0, done}, 32'd0);
        @(negedge clk);

        start = 1'b1;
        op    = 3'b010;
        a     = 32'd100;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2;
        chk("middiv_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("middiv_rst_busy", {31'd0, busy}, 32'd0);
        chk("middiv_rst_hi", hi, 32'd0);
        chk("middiv_rst_lo", lo, 32'd0);
        chk("middiv_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (45) @(negedge clk);
        chk("after_rst_hi", hi, 32'd0);
        chk("after_rst_lo", lo, 32'd0);
        chk("pending_expect", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit with HI/LO result registers, sitting directly downstream of the register file in the single-cycle datapath. It consumes the two register-file read ports (RD1, RD2) as operands and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. Results are held in HI/LO, where MFHI/MFLO read them. The unit raises `busy` so the control stage stalls any instruction that needs HI/LO or the unit until the operation completes.

## Interface
- MUL_CYCLES, 5: number of busy cycles for MULT/MULTU (range 1..32).
- DIV_CYCLES, 32: number of busy cycles for DIV/DIVU. The divider is fixed radix-2 (one quotient bit per cycle), so this value must be 32.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active low.
- start  in  1  operation request, sampled at the rising edge of clk.
- op  in  3  operation code: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 11x are no-ops.
- a  in  32  operand A, driven from register-file RD1 (rs).
- b  in  32  operand B, driven from register-file RD2 (rt).
- busy  out  1  high while a multiply or divide is in progress.
- done  out  1  one-cycle pulse in the first cycle in which the new HI/LO values are visible.
- hi  out  32  HI register.
- lo  out  32  LO register.

## Operation
- **Reset:** `rst_n`=0 asynchronously forces hi=0, lo=0, busy=0, done=0, state=IDLE and counter=0.
- **States:**
  - IDLE: busy=0.
  - MUL: busy=1.
  - DIV: busy=1.
- **Accept:** an operation is accepted at a rising edge where start=1 and busy=0.
  - Operands a and b are captured at that edge; later changes on a/b have no effect.
  - start while busy=1 is ignored. It is neither queued nor an error.
- **MTHI/MTLO:** hi (or lo) is loaded with `a` at the accepting edge.
  - The state stays IDLE; busy and done stay 0.
- **MULT/MULTU:**
  - IDLE→MUL, counter=MUL_CYCLES-1.
  - Each edge in MUL decrements the counter.
  - At the edge where the counter is 0: {hi,lo} is written with the 64-bit product, the state returns to IDLE and done=1 for the following cycle.
  - MULT treats the operands as two's complement; MULTU as unsigned.
  - The product is exact in 64 bits, so overflow is impossible.
- **DIV/DIVU:**
  - IDLE→DIV. The divider runs a restoring shift-subtract over magnitudes, one quotient bit per edge, for 32 edges.
  - After the 32nd edge: lo=quotient, hi=remainder, the state returns to IDLE and done=1.
  - DIV signs: the quotient truncates toward zero and the remainder takes the dividend's sign. Signs are corrected at the final edge.
- **Divide by zero (b=0):** still takes 32 cycles. Result: lo=0xFFFFFFFF, hi=a, for both DIV and DIVU.
- **Signed overflow (DIV with a=0x80000000, b=0xFFFFFFFF):** lo=0x80000000, hi=0.
- **HI/LO stability:** hi/lo hold their old values throughout MUL/DIV. Only the completion edge or an MTHI/MTLO edge changes them.

## Timing
- **MTHI/MTLO latency:** 1 edge. The new value is visible in the cycle after the accepting edge.
- **MULT/MULTU latency:** busy is high for exactly MUL_CYCLES cycles after the accepting edge. hi/lo update and done=1 in cycle MUL_CYCLES+1, counting the accepting edge as edge 0.
- **DIV/DIVU latency:** busy is high for exactly 32 cycles; done and the new hi/lo appear in cycle 33.
- **Back-to-back issue:** done=1 and busy=0 occur in the same cycle, so a new start is accepted at that cycle's edge. The sustained rate is one multiply per MUL_CYCLES+1 cycles.
- **Reset mid-operation:** the in-flight result is discarded, hi/lo become 0, and busy drops immediately (asynchronously).
- **Stalling:** there is no stall input. The control stage must hold MFHI/MFLO until busy=0, and the unit does not check for this.

## Test plan
- **Signed multiply:** after reset, start MULT with a=0xFFFFFFFD (-3), b=5. Required: busy=1 for 5 cycles, then done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- **Unsigned multiply, max operands:** MULTU with a=b=0xFFFFFFFF. Required: hi=0xFFFFFFFE, lo=0x00000001.
  - Then MULT with the same operands. Required: hi=0, lo=1.
- **Signed divide:** DIV with a=0xFFFFFFF9 (-7), b=2. Required: busy for 32 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - DIVU with a=100, b=7. Required: lo=14, hi=2.
- **Boundary divides:**
  - DIVU with a=7, b=0. Required: lo=0xFFFFFFFF, hi=7.
  - DIV with a=0x80000000, b=0xFFFFFFFF. Required: lo=0x80000000, hi=0.
- **Ignored start and back-to-back issue:** start MULT 2×3, then pulse start with DIVU 9/3 while busy. Required: result hi=0, lo=6, and the divide never runs.
  - Then issue MTHI a=0x1234 in the done cycle. Required: accepted at the next edge, hi=0x1234, lo=6.
- **Reset mid-divide:** assert rst_n=0 during cycle 10 of a DIV. Required: busy=0, hi=lo=0 without a clock edge, and no done pulse after reset is released.
